// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial word link: FSM state encoding, default word size, parity helper.
// The parity path is only exercised when SERIAL_PARITY_EN is defined.
package serial_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_PARITY  = 2'd2
   } state_t;

   localparam int DEFAULT_WORD_LENGTH = 8;
   localparam int MAX_PARITY_WIDTH    = 64;

   // Even parity over a zero-extended vector: 1 means an odd number of ones was seen.
   function automatic logic even_parity(input logic [MAX_PARITY_WIDTH-1:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/serial_word_deserializer_bit_counter.sv
// Bit counter for the deserializer: sync clear, count enable, and a terminal flag on the
// last data bit of the frame. Wraps to zero when the terminal bit is counted.
module bit_counter #(
   parameter int WORD_LENGTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int COUNT_WIDTH = $clog2(WORD_LENGTH + 1);
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WORD_LENGTH - 1);

   logic [COUNT_WIDTH-1:0] count;

   assign terminal = (count == LAST_COUNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (terminal) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_word_deserializer.sv
// MSB-first serial-to-parallel receiver with a one-deep valid/ready output slot and sticky overrun.
// Define SERIAL_PARITY_EN to add a trailing even-parity bit per frame and drive parityError.
module serial_word_deserializer
   import serial_link_pkg::*;
#(
   parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   serialInput,
   input  logic                   shift,
   input  logic                   clearOverrun,
   input  logic                   outReady,
   output logic [WORD_LENGTH-1:0] parallelOutput,
   output logic                   outValid,
   output logic                   busy,
   output logic                   overrun,
   output logic                   parityError
);

`ifdef SERIAL_PARITY_EN
   localparam state_t AFTER_DATA = ST_PARITY;
`else
   localparam state_t AFTER_DATA = ST_IDLE;
`endif

   state_t                 state;
   state_t                 next_state;
   logic [WORD_LENGTH-1:0] shift_reg;
   logic [WORD_LENGTH-1:0] word_in;
   logic                   last_bit;
   logic                   count_en;
   logic                   word_done;
   logic                   slot_free;

   bit_counter #(
      .WORD_LENGTH(WORD_LENGTH)
   ) u_bit_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (start),
      .enable   (count_en),
      .terminal (last_bit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // start overrides everything, including a strobe arriving on the same cycle.
   always_comb begin
      next_state = state;
      if (start) begin
         next_state = ST_RECEIVE;
      end else begin
         unique case (state)
            ST_RECEIVE: if (shift && last_bit) next_state = AFTER_DATA;
            ST_PARITY:  if (shift) next_state = ST_IDLE;
            default:    next_state = state;
         endcase
      end
   end

   always_comb begin
      count_en  = 1'b0;
      word_done = 1'b0;
      if (!start) begin
         unique case (state)
            ST_RECEIVE: begin
               count_en = shift;
`ifndef SERIAL_PARITY_EN
               word_done = shift && last_bit;
`endif
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: word_done = shift;
`endif
            default: begin
               count_en  = 1'b0;
               word_done = 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

`ifdef SERIAL_PARITY_EN
   assign word_in = shift_reg;
`else
   assign word_in = {shift_reg[WORD_LENGTH-2:0], serialInput};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
      end else if (count_en) begin
         shift_reg <= {shift_reg[WORD_LENGTH-2:0], serialInput};
      end
   end

   // A consume on the completing edge frees the slot for the incoming word.
   assign slot_free = !outValid || outReady;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parallelOutput <= '0;
         outValid       <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (word_done && slot_free) begin
            parallelOutput <= word_in;
            outValid       <= 1'b1;
         end else if (outValid && outReady) begin
            outValid <= 1'b0;
         end

         if (word_done && !slot_free) begin
            overrun <= 1'b1;
         end else if (clearOverrun) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef SERIAL_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parityError <= 1'b0;
      end else if (word_done && slot_free) begin
         parityError <= even_parity(MAX_PARITY_WIDTH'({shift_reg, serialInput}));
      end
   end
`else
   assign parityError = 1'b0;
`endif

endmodule
